// File: rtl/gs_pkg.sv
// Shared definitions for the GS raw-signal readback path: command codes,
// arbiter state encoding, settle-counter bounds and requester owner IDs.
package gs_pkg;

   // GS command codes used by the host command decoder
   localparam logic [7:0] GS_CMD_NOP     = 8'h00;
   localparam logic [7:0] GS_CMD_RD_RAW  = 8'h01;
   localparam logic [7:0] GS_CMD_WR_CFG  = 8'h02;
   localparam logic [7:0] GS_CMD_STATUS  = 8'h03;
   localparam logic [7:0] GS_CMD_RESET   = 8'hFF;

   // Settle counter bounds; the counter is wide enough for the maximum
   localparam int GS_SETTLE_MIN = 1;
   localparam int GS_SETTLE_MAX = 15;
   localparam int GS_CNT_W      = 4;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      GS_IDLE   = 2'd0,
      GS_SETTLE = 2'd1,
      GS_CAPT   = 2'd2
   } gsArbState_t;

   // Owner of the transaction in flight
   typedef enum logic {
      GS_OWNER_A = 1'b0,
      GS_OWNER_B = 1'b1
   } gsOwner_t;

   // Clamp a requested settle length into the legal counter range
   function automatic logic [GS_CNT_W-1:0] gsSettleLoad(input int cyc);
      int clamped;
      clamped = cyc;
      if (clamped < GS_SETTLE_MIN) clamped = GS_SETTLE_MIN;
      if (clamped > GS_SETTLE_MAX) clamped = GS_SETTLE_MAX;
      return clamped[GS_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/gs_rr_pick2.sv
// Two-way round-robin pick: a lone request always wins, on a tie the
// requester holding priority wins. Purely combinational.
module gs_rr_pick2 (
   input  logic       i_reqA,
   input  logic       i_reqB,
   input  logic       i_prioB,
   output logic [1:0] o_grant
);

   // One-hot grant: bit 0 is requester A, bit 1 is requester B
   always_comb begin
      o_grant = 2'b00;
      if (i_reqA && i_reqB) begin
         o_grant = i_prioB ? 2'b10 : 2'b01;
      end else if (i_reqA) begin
         o_grant = 2'b01;
      end else if (i_reqB) begin
         o_grant = 2'b10;
      end
   end

endmodule

// File: rtl/gs_rawsig_arbiter.sv
// Arbitrates the shared raw-signal bank between the state machine (A) and
// host readback (B). The winner's address/select are driven onto the bank,
// held for SETTLE_CYC cycles, then the bank data is captured and handed back.
module gs_rawsig_arbiter
   import gs_pkg::*;
#(
   parameter int SETTLE_CYC   = 1,
   parameter bit PRIO_A_RESET = 1'b1
) (
   input  logic        iClk,
   input  logic        iReset,
   input  logic        iReqA,
   input  logic [7:0]  i8AddrA,
   input  logic [7:0]  i8SelA,
   output logic        oGntA,
   output logic        oVldA,
   input  logic        iReqB,
   input  logic [7:0]  i8AddrB,
   input  logic [7:0]  i8SelB,
   output logic        oGntB,
   output logic        oVldB,
   output logic [15:0] o16Data,
   output logic [7:0]  o8Addr,
   output logic [7:0]  o8SignSelec,
   input  logic [15:0] i16Reg,
   output logic        oBusy
);

   localparam logic [GS_CNT_W-1:0] C_SETTLE_LOAD = gsSettleLoad(SETTLE_CYC);

   gsArbState_t         r_state;
   gsArbState_t         w_nextState;
   logic [GS_CNT_W-1:0] r_cnt;
   gsOwner_t            r_owner;
   logic                r_prioB;
   logic [7:0]          r_addr;
   logic [7:0]          r_sel;
   logic [15:0]         r_data;
   logic                r_gntA;
   logic                r_gntB;
   logic                r_vldA;
   logic                r_vldB;

   logic [1:0]          w_grant;
   logic                w_load;
   logic                w_capt;
   logic                w_busy;

   // Requests are looked at raw; only IDLE acts on the pick
   gs_rr_pick2 u_pick (
      .i_reqA  (iReqA),
      .i_reqB  (iReqB),
      .i_prioB (r_prioB),
      .o_grant (w_grant)
   );

   // State register; reset drops any transaction in flight
   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         r_state <= GS_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: IDLE waits for a request, SETTLE runs the counter down to 1
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         GS_IDLE: begin
            if (w_grant != 2'b00) w_nextState = GS_SETTLE;
         end
         GS_SETTLE: begin
            if (r_cnt <= {{(GS_CNT_W-1){1'b0}}, 1'b1}) w_nextState = GS_CAPT;
         end
         GS_CAPT: begin
            w_nextState = GS_IDLE;
         end
         default: begin
            w_nextState = GS_IDLE;
         end
      endcase
   end

   // FSM outputs: load strobe in IDLE, capture strobe in CAPT, busy otherwise
   always_comb begin
      w_busy = 1'b1;
      w_load = 1'b0;
      w_capt = 1'b0;
      unique case (r_state)
         GS_IDLE: begin
            w_busy = 1'b0;
            w_load = (w_grant != 2'b00);
         end
         GS_SETTLE: begin
            w_busy = 1'b1;
         end
         GS_CAPT: begin
            w_capt = 1'b1;
         end
         default: begin
            w_busy = 1'b0;
         end
      endcase
   end

   // Settle counter, loaded on acceptance and run down while settling
   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         r_cnt <= '0;
      end else if (w_load) begin
         r_cnt <= C_SETTLE_LOAD;
      end else if (r_state == GS_SETTLE && r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Owner and priority pointer move only when a request is accepted
   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         r_owner <= GS_OWNER_A;
         r_prioB <= ~PRIO_A_RESET;
      end else if (w_load) begin
         r_owner <= w_grant[1] ? GS_OWNER_B : GS_OWNER_A;
         r_prioB <= ~w_grant[1];
      end
   end

   // Bank address/select latched from the winner and held until the next grant
   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         r_addr <= '0;
         r_sel  <= '0;
      end else if (w_load) begin
         r_addr <= w_grant[1] ? i8AddrB : i8AddrA;
         r_sel  <= w_grant[1] ? i8SelB  : i8SelA;
      end
   end

   // Grant pulse for the accepted requester, one cycle after sampling
   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         r_gntA <= 1'b0;
         r_gntB <= 1'b0;
      end else begin
         r_gntA <= w_load & w_grant[0];
         r_gntB <= w_load & w_grant[1];
      end
   end

   // Capture bank data and flag it valid to the owner in the following cycle
   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         r_data <= '0;
         r_vldA <= 1'b0;
         r_vldB <= 1'b0;
      end else begin
         if (w_capt) r_data <= i16Reg;
         r_vldA <= w_capt & (r_owner == GS_OWNER_A);
         r_vldB <= w_capt & (r_owner == GS_OWNER_B);
      end
   end

   assign oGntA       = r_gntA;
   assign oGntB       = r_gntB;
   assign oVldA       = r_vldA;
   assign oVldB       = r_vldB;
   assign o16Data     = r_data;
   assign o8Addr      = r_addr;
   assign o8SignSelec = r_sel;
   assign oBusy       = w_busy;

endmodule

// File: tb/tb_gs_rawsig_arbiter.sv
// Bench for gs_rawsig_arbiter: one instance with a 1-cycle settle drives the
// table and the arbitration sequences, a second with a 4-cycle settle covers
// the longer hold. Captured data is checked through a scoreboard queue.
module tb_gs_rawsig_arbiter;

   typedef struct {
      logic       reqA;
      logic       reqB;
      logic [7:0] addrA;
      logic [7:0] selA;
      logic [7:0] addrB;
      logic [7:0] selB;
      logic       expOwner;
      logic [7:0] expAddr;
      logic [7:0] expSel;
   } vec_t;

   typedef struct {
      logic        owner;
      logic [15:0] data;
   } sbEntry_t;

   logic        clk;
   logic        rst_n;
   logic        reqA, reqB;
   logic [7:0]  addrA, selA, addrB, selB;
   logic        gntA, gntB, vldA, vldB, busy;
   logic [15:0] data, reg16;
   logic [7:0]  addr, sel;

   logic        reqA4, reqB4;
   logic [7:0]  addrA4, selA4, addrB4, selB4;
   logic        gntA4, gntB4, vldA4, vldB4, busy4;
   logic [15:0] data4, reg164;
   logic [7:0]  addr4, sel4;

   int          vecCount;
   int          missCount;
   sbEntry_t    sbQ[$];
   vec_t        vecs[8];

   // Raw-signal bank model: one fixed location, the rest derived from addr/sel
   function automatic logic [15:0] bankModel(input logic [7:0] a, input logic [7:0] s);
      if (a == 8'h05 && s == 8'h02) return 16'hABCD;
      return {a ^ 8'hA5, s + 8'h3C};
   endfunction

   assign reg16  = bankModel(addr, sel);
   assign reg164 = bankModel(addr4, sel4);

   gs_rawsig_arbiter #(.SETTLE_CYC(1), .PRIO_A_RESET(1'b1)) dut (
      .iClk(clk), .iReset(rst_n),
      .iReqA(reqA), .i8AddrA(addrA), .i8SelA(selA), .oGntA(gntA), .oVldA(vldA),
      .iReqB(reqB), .i8AddrB(addrB), .i8SelB(selB), .oGntB(gntB), .oVldB(vldB),
      .o16Data(data), .o8Addr(addr), .o8SignSelec(sel), .i16Reg(reg16), .oBusy(busy)
   );

   gs_rawsig_arbiter #(.SETTLE_CYC(4), .PRIO_A_RESET(1'b1)) dut4 (
      .iClk(clk), .iReset(rst_n),
      .iReqA(reqA4), .i8AddrA(addrA4), .i8SelA(selA4), .oGntA(gntA4), .oVldA(vldA4),
      .iReqB(reqB4), .i8AddrB(addrB4), .i8SelB(selB4), .oGntB(gntB4), .oVldB(vldB4),
      .o16Data(data4), .o8Addr(addr4), .o8SignSelec(sel4), .i16Reg(reg164), .oBusy(busy4)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every valid pulse of the main instance must match the oldest expected entry
   always @(negedge clk) begin : scoreMon
      sbEntry_t e;
      if (rst_n && (vldA || vldB)) begin
         checkOutput("vldOverlap", 32'(vldA & vldB), 32'd0);
         if (sbQ.size() == 0) begin
            checkOutput("unexpectedVld", 32'({vldA, vldB}), 32'd0);
         end else begin
            e = sbQ.pop_front();
            checkOutput("vldOwner", 32'({vldA, vldB}), e.owner ? 32'd1 : 32'd2);
            checkOutput("vldData", 32'(data), 32'(e.data));
         end
      end
   end

   // One table transaction: request, check grant, drop request, wait for valid
   task automatic applyStimulus(input vec_t v, input int idx);
      sbEntry_t e;
      int       lat;
      reqA  = v.reqA;  reqB = v.reqB;
      addrA = v.addrA; selA = v.selA;
      addrB = v.addrB; selB = v.selB;
      e.owner = v.expOwner;
      e.data  = bankModel(v.expAddr, v.expSel);
      sbQ.push_back(e);
      @(negedge clk);
      checkOutput($sformatf("v%0d.gnt", idx), 32'({gntA, gntB}), v.expOwner ? 32'd1 : 32'd2);
      checkOutput($sformatf("v%0d.addr", idx), 32'(addr), 32'(v.expAddr));
      checkOutput($sformatf("v%0d.sel", idx), 32'(sel), 32'(v.expSel));
      checkOutput($sformatf("v%0d.busy", idx), 32'(busy), 32'd1);
      reqA = 1'b0; reqB = 1'b0;
      addrA = ~addrA; selA = ~selA; addrB = ~addrB; selB = ~selB;
      lat = 0;
      while (!(vldA || vldB) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput($sformatf("v%0d.lat", idx), 32'(lat), 32'd2);
      @(negedge clk);
      checkOutput($sformatf("v%0d.vldPulse", idx), 32'({vldA, vldB}), 32'd0);
      checkOutput($sformatf("v%0d.hold", idx), 32'(data), 32'(e.data));
   endtask

   // Wait for the scoreboard to empty within a bounded number of cycles
   task automatic drainScoreboard(input string name);
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(sbQ.size()), 32'd0);
      @(negedge clk);
   endtask

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0] order[4];
      int         nGnt;
      int         busyCnt;
      int         vldIdx;
      logic       anyB4;
      sbEntry_t   e;

      vecCount = 0; missCount = 0;
      reqA = 0; reqB = 0; addrA = 0; selA = 0; addrB = 0; selB = 0;
      reqA4 = 0; reqB4 = 0; addrA4 = 0; selA4 = 0; addrB4 = 0; selB4 = 0;

      vecs[0] = '{1'b1, 1'b0, 8'h05, 8'h02, 8'h00, 8'h00, 1'b0, 8'h05, 8'h02};
      vecs[1] = '{1'b0, 1'b1, 8'h77, 8'h77, 8'h10, 8'h20, 1'b1, 8'h10, 8'h20};
      vecs[2] = '{1'b1, 1'b1, 8'h21, 8'h01, 8'h42, 8'h03, 1'b0, 8'h21, 8'h01};
      vecs[3] = '{1'b1, 1'b1, 8'h31, 8'h11, 8'h52, 8'h13, 1'b1, 8'h52, 8'h13};
      vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h63, 8'h07, 1'b1, 8'h63, 8'h07};
      vecs[5] = '{1'b1, 1'b1, 8'h24, 8'h08, 8'h66, 8'h09, 1'b0, 8'h24, 8'h08};
      vecs[6] = '{1'b1, 1'b0, 8'h35, 8'h0F, 8'h00, 8'h00, 1'b0, 8'h35, 8'h0F};
      vecs[7] = '{1'b1, 1'b1, 8'h44, 8'h44, 8'h88, 8'h88, 1'b1, 8'h88, 8'h88};

      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rstCtl", 32'({gntA, gntB, vldA, vldB, busy}), 32'd0);
      checkOutput("rstData", 32'(data), 32'd0);
      checkOutput("rstAddrSel", 32'({addr, sel}), 32'd0);
      checkOutput("rstCtl4", 32'({gntA4, gntB4, vldA4, vldB4, busy4}), 32'd0);

      // Release reset and present the first request in the same cycle
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);
      drainScoreboard("tableDrain");

      // Both requesters held from reset: grants alternate starting with A
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      reqA = 1; addrA = 8'h12; selA = 8'h34;
      reqB = 1; addrB = 8'h56; selB = 8'h78;
      for (int i = 0; i < 4; i++) begin
         e.owner = i[0];
         e.data  = i[0] ? bankModel(8'h56, 8'h78) : bankModel(8'h12, 8'h34);
         sbQ.push_back(e);
         order[i] = 2'b11;
      end
      nGnt = 0;
      for (int c = 0; c < 40 && nGnt < 4; c++) begin
         @(negedge clk);
         if (gntA || gntB) begin
            checkOutput("gntOverlap", 32'(gntA & gntB), 32'd0);
            order[nGnt] = {gntA, gntB};
            nGnt++;
            if (nGnt == 4) begin reqA = 0; reqB = 0; end
         end
      end
      reqA = 0; reqB = 0;
      checkOutput("rrOrder0", 32'(order[0]), 32'd2);
      checkOutput("rrOrder1", 32'(order[1]), 32'd1);
      checkOutput("rrOrder2", 32'(order[2]), 32'd2);
      checkOutput("rrOrder3", 32'(order[3]), 32'd1);
      drainScoreboard("rrDrain");

      // A held for ten cycles: a grant every third cycle
      reqA = 1; addrA = 8'h0A; selA = 8'h0B;
      for (int i = 0; i < 4; i++) begin
         e.owner = 1'b0;
         e.data  = bankModel(8'h0A, 8'h0B);
         sbQ.push_back(e);
      end
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         checkOutput($sformatf("b2bGnt%0d", i), 32'({gntA, gntB}), (i % 3 == 1) ? 32'd2 : 32'd0);
         if (i == 10) reqA = 0;
      end
      drainScoreboard("b2bDrain");

      // Reset while settling: outputs clear at once and the transaction is lost
      reqA = 1; addrA = 8'h99; selA = 8'h98;
      @(negedge clk);
      reqA = 0;
      rst_n = 1'b0;
      #1;
      checkOutput("midRstCtl", 32'({gntA, gntB, vldA, vldB, busy}), 32'd0);
      checkOutput("midRstData", 32'(data), 32'd0);
      checkOutput("midRstAddrSel", 32'({addr, sel}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("postRstVld", 32'({vldA, vldB}), 32'd0);
      end
      applyStimulus('{1'b1, 1'b1, 8'hC1, 8'hC2, 8'hD1, 8'hD2, 1'b0, 8'hC1, 8'hC2}, 8);
      drainScoreboard("rstDrain");

      // Four-cycle settle: busy for five cycles, address held across input changes
      reqA4 = 1; addrA4 = 8'h33; selA4 = 8'h44;
      busyCnt = 0; vldIdx = 0; anyB4 = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (busy4) busyCnt++;
         if (gntB4 || vldB4) anyB4 = 1'b1;
         if (i == 1) begin
            checkOutput("s4Gnt", 32'(gntA4), 32'd1);
            reqA4 = 0; addrA4 = 8'h77; selA4 = 8'h66;
         end
         if (i == 3) checkOutput("s4AddrHold", 32'({addr4, sel4}), 32'h3344);
         if (vldA4) begin
            vldIdx = i;
            checkOutput("s4Data", 32'(data4), 32'(bankModel(8'h33, 8'h44)));
         end
      end
      checkOutput("s4Busy", 32'(busyCnt), 32'd5);
      checkOutput("s4VldAt", 32'(vldIdx), 32'd6);
      checkOutput("s4NoB", 32'(anyB4), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
